// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer
//   Holds a 2x16 character frame buffer written by the host and streams a
//   full-screen update to the LCD1602 byte driver over valid/ready:
//   row-1 address command, 16 characters, row-2 address command, 16 characters.
//   The downstream driver owns all en/rs/rw pin timing.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   wr_en         host write strobe, one cell per cycle, always accepted
//   wr_addr[4:0]  cell index: 0-15 row 1, 16-31 row 2
//   wr_data[7:0]  character code
//   refresh       single-cycle request for a full-screen rewrite
//   out_valid     out_rs/out_data hold a byte for the driver
//   out_rs        0 = command byte, 1 = character byte
//   out_data[7:0] byte to the driver
//   out_ready     driver accepts the byte at this edge
//   busy          frame in progress
//   frame_done    one-cycle pulse after the last byte of a frame transfers
module lcd_frame_sequencer #(
    parameter logic [7:0] FILL_CHAR    = 8'h20,
    parameter bit         AUTO_REFRESH = 1'b1,
    parameter logic [7:0] ROW1_CMD_VAL = 8'h80,
    parameter logic [7:0] ROW2_CMD_VAL = 8'hC0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    output logic       out_valid,
    output logic       out_rs,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_R1CMD,
        S_R1CHR,
        S_R2CMD,
        S_R2CHR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        col_q, col_d;
    logic [31:0][7:0]  mem_q, mem_d;
    logic              dirty_q, dirty_d;
    logic              req_q, req_d;
    logic              out_valid_q, out_valid_d;
    logic              out_rs_q, out_rs_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              frame_done_q, frame_done_d;

    logic              xfer;
    logic              leave_idle;
    logic [3:0]        col_inc;

    assign xfer    = out_valid_q && out_ready;
    assign col_inc = col_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        mem_d        = mem_q;
        dirty_d      = dirty_q;
        req_d        = req_q;
        out_valid_d  = out_valid_q;
        out_rs_d     = out_rs_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;
        leave_idle   = 1'b0;

        // The next byte is loaded on the transfer edge itself, so the
        // character index used here is the column that follows the one
        // just accepted. mem_q is the pre-write value: a write on the
        // same edge only shows up in later frames.
        case (state_q)
            S_IDLE: begin
                if (req_q || (AUTO_REFRESH && dirty_q)) begin
                    state_d     = S_R1CMD;
                    leave_idle  = 1'b1;
                    out_valid_d = 1'b1;
                    out_rs_d    = 1'b0;
                    out_data_d  = ROW1_CMD_VAL;
                end
            end
            S_R1CMD: begin
                if (xfer) begin
                    state_d    = S_R1CHR;
                    col_d      = 4'd0;
                    out_rs_d   = 1'b1;
                    out_data_d = mem_q[5'd0];
                end
            end
            S_R1CHR: begin
                if (xfer) begin
                    if (col_q == 4'd15) begin
                        state_d    = S_R2CMD;
                        out_rs_d   = 1'b0;
                        out_data_d = ROW2_CMD_VAL;
                    end else begin
                        col_d      = col_inc;
                        out_data_d = mem_q[{1'b0, col_inc}];
                    end
                end
            end
            S_R2CMD: begin
                if (xfer) begin
                    state_d    = S_R2CHR;
                    col_d      = 4'd0;
                    out_rs_d   = 1'b1;
                    out_data_d = mem_q[5'd16];
                end
            end
            S_R2CHR: begin
                if (xfer) begin
                    if (col_q == 4'd15) begin
                        state_d      = S_DONE;
                        col_d        = 4'd0;
                        out_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        col_d      = col_inc;
                        out_data_d = mem_q[{1'b1, col_inc}];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Flags clear when a frame starts; a write or refresh on that
        // same edge re-arms them so another frame follows.
        if (leave_idle) begin
            dirty_d = 1'b0;
            req_d   = 1'b0;
        end
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
            dirty_d        = 1'b1;
        end
        if (refresh) begin
            req_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= 4'd0;
            mem_q        <= {32{FILL_CHAR}};
            dirty_q      <= 1'b0;
            req_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_rs_q     <= 1'b0;
            out_data_q   <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            mem_q        <= mem_d;
            dirty_q      <= dirty_d;
            req_q        <= req_d;
            out_valid_q  <= out_valid_d;
            out_rs_q     <= out_rs_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_rs     = out_rs_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != S_IDLE);

endmodule
